// File: rtl/instruction_frame_assembler_if.sv
// RX byte stream in, parallel instruction fields and frame status out.
// master = UART/loader side, slave = frame assembler.
interface instruction_frame_assembler_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] opcode;
  logic [7:0] sel;
  logic [7:0] op1h;
  logic [7:0] op1l;
  logic [7:0] op2h;
  logic [7:0] op2l;
  logic       load;
  logic       busy;
  logic       done;
  logic [7:0] instr_cnt;
  logic [7:0] err_cnt;

  modport master (
    output rx_data, rx_valid,
    input  opcode, sel, op1h, op1l, op2h, op2l,
    input  load, busy, done, instr_cnt, err_cnt
  );

  modport slave (
    input  rx_data, rx_valid,
    output opcode, sel, op1h, op1l, op2h, op2l,
    output load, busy, done, instr_cnt, err_cnt
  );
endinterface

// File: rtl/instruction_frame_assembler.sv
// Frames sync + 6 field bytes (+ XOR checksum when CHECKSUM_EN is defined) into one instruction.
// Latency: load pulses 1 clk after the frame's final accepted byte.
// Backpressure: none; rx_valid is accepted every cycle, bytes outside a frame or after done are dropped.
module instruction_frame_assembler #(
  parameter int         NUMBER_OF_INSTRUCTIONS = 4,
  parameter logic [7:0] SYNC_BYTE              = 8'hA5,
  parameter int         TIMEOUT_CYCLES         = 100000
) (
  input logic                         clk,
  input logic                         rst,
  instruction_frame_assembler_if.slave bus
);

  localparam int            TW     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]    N_LAST = 8'(NUMBER_OF_INSTRUCTIONS - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FIELDS = 2'd1;
`ifdef CHECKSUM_EN
  localparam logic [1:0] S_CHECK  = 2'd2;
`endif

  logic [1:0]    state;
  logic [2:0]    idx;
  logic [TW-1:0] timer;
`ifdef CHECKSUM_EN
  logic [7:0]    xsum;
`endif

  logic [7:0] opcode_q, sel_q, op1h_q, op1l_q, op2h_q, op2l_q;
  logic       load_q;
  logic       done_q;
  logic [7:0] instr_q;
  logic [7:0] err_q;

  logic start;
  logic take_field;
  logic last_field;
  logic timeout;
  logic deliver;
  logic bad;

  always_comb begin
    start      = (state == S_IDLE) && bus.rx_valid && (bus.rx_data == SYNC_BYTE) && !done_q;
    take_field = (state == S_FIELDS) && bus.rx_valid;
    last_field = take_field && (idx == 3'd5);
    // A byte arriving on the expiry cycle wins, so timeout needs !rx_valid.
    timeout    = (state != S_IDLE) && !bus.rx_valid && (timer == T_LAST);
`ifdef CHECKSUM_EN
    deliver    = (state == S_CHECK) && bus.rx_valid && (bus.rx_data == xsum);
    bad        = timeout || ((state == S_CHECK) && bus.rx_valid && (bus.rx_data != xsum));
`else
    deliver    = last_field;
    bad        = timeout;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      idx   <= 3'd0;
      timer <= '0;
`ifdef CHECKSUM_EN
      xsum  <= 8'h00;
`endif
    end else begin
      if ((state == S_IDLE) || bus.rx_valid || timeout) begin
        timer <= '0;
      end else begin
        timer <= timer + 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_FIELDS;
            idx   <= 3'd0;
`ifdef CHECKSUM_EN
            xsum  <= 8'h00;
`endif
          end
        end
        S_FIELDS: begin
          if (timeout) begin
            state <= S_IDLE;
            idx   <= 3'd0;
          end else if (take_field) begin
`ifdef CHECKSUM_EN
            xsum <= xsum ^ bus.rx_data;
`endif
            if (last_field) begin
              idx <= 3'd0;
`ifdef CHECKSUM_EN
              state <= S_CHECK;
`else
              state <= S_IDLE;
`endif
            end else begin
              idx <= idx + 3'd1;
            end
          end
        end
`ifdef CHECKSUM_EN
        S_CHECK: begin
          if (timeout || bus.rx_valid) begin
            state <= S_IDLE;
          end
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

  // Field registers hold the last frame until the next frame's first field byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      opcode_q <= 8'h00;
      sel_q    <= 8'h00;
      op1h_q   <= 8'h00;
      op1l_q   <= 8'h00;
      op2h_q   <= 8'h00;
      op2l_q   <= 8'h00;
    end else if (take_field) begin
      case (idx)
        3'd0:    opcode_q <= bus.rx_data;
        3'd1:    sel_q    <= bus.rx_data;
        3'd2:    op1h_q   <= bus.rx_data;
        3'd3:    op1l_q   <= bus.rx_data;
        3'd4:    op2h_q   <= bus.rx_data;
        3'd5:    op2l_q   <= bus.rx_data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      load_q  <= 1'b0;
      done_q  <= 1'b0;
      instr_q <= 8'h00;
      err_q   <= 8'h00;
    end else begin
      load_q <= deliver;
      if (deliver) begin
        instr_q <= instr_q + 8'd1;
        if (instr_q == N_LAST) begin
          done_q <= 1'b1;
        end
      end
      if (bad && (err_q != 8'hFF)) begin
        err_q <= err_q + 8'd1;
      end
    end
  end

  assign bus.opcode    = opcode_q;
  assign bus.sel       = sel_q;
  assign bus.op1h      = op1h_q;
  assign bus.op1l      = op1l_q;
  assign bus.op2h      = op2h_q;
  assign bus.op2l      = op2l_q;
  assign bus.load      = load_q;
  assign bus.busy      = (state != S_IDLE);
  assign bus.done      = done_q;
  assign bus.instr_cnt = instr_q;
  assign bus.err_cnt   = err_q;

endmodule

// File: tb/tb_instruction_frame_assembler.sv
// Directed bench for instruction_frame_assembler; frames carry a checksum byte when CHECKSUM_EN is defined.
module tb_instruction_frame_assembler;

  localparam int NI = 4;
  localparam int TO = 20;

  logic clk;
  logic rst;
  instruction_frame_assembler_if bus();

  instruction_frame_assembler #(
    .NUMBER_OF_INSTRUCTIONS(NI),
    .SYNC_BYTE(8'hA5),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int load_cnt = 0;
  logic [7:0] exp_instr = 8'd0;
  logic [7:0] exp_err   = 8'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (bus.load === 1'b1) load_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1, "watchdog");
  end

  // Caller is at posedge+1; returns at posedge+1 after the byte was sampled.
  task automatic send_byte(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_fields(input logic [47:0] f);
    send_byte(8'hA5);
    for (int i = 0; i < 6; i++) send_byte(f[47-8*i -: 8]);
  endtask

`ifdef CHECKSUM_EN
  function automatic logic [7:0] xor6(input logic [47:0] f);
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i < 6; i++) x = x ^ f[47-8*i -: 8];
    return x;
  endfunction
`endif

  task automatic send_frame(input logic [47:0] f);
    send_fields(f);
`ifdef CHECKSUM_EN
    send_byte(xor6(f));
`endif
  endtask

  function automatic logic [47:0] fields_now();
    return {bus.opcode, bus.sel, bus.op1h, bus.op1l, bus.op2h, bus.op2l};
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_instr = 8'd0;
    exp_err   = 8'd0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (fields_now() !== 48'h0) begin n_fail++; $display("FAIL reset_fields got %h want 0", fields_now()); end
    n_cmp++; if ({bus.load, bus.busy, bus.done} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b want 000", {bus.load, bus.busy, bus.done}); end
    n_cmp++; if ({bus.instr_cnt, bus.err_cnt} !== 16'h0) begin n_fail++; $display("FAIL reset_counts got %h want 0000", {bus.instr_cnt, bus.err_cnt}); end
  endtask

  task automatic test_good_frame();
    logic [47:0] f;
    int base;
    f = 48'h01_02_10_20_30_40;
    base = load_cnt;
    send_frame(f);
    exp_instr++;
    n_cmp++; if (bus.load !== 1'b1) begin n_fail++; $display("FAIL good_load got %b want 1", bus.load); end
    n_cmp++; if (fields_now() !== f) begin n_fail++; $display("FAIL good_fields got %h want %h", fields_now(), f); end
    n_cmp++; if (bus.instr_cnt !== exp_instr) begin n_fail++; $display("FAIL good_instr got %0d want %0d", bus.instr_cnt, exp_instr); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL good_busy got %b want 0", bus.busy); end
    @(posedge clk); #1;
    n_cmp++; if (bus.load !== 1'b0) begin n_fail++; $display("FAIL good_load_pulse got %b want 0", bus.load); end
    n_cmp++; if (load_cnt - base !== 1) begin n_fail++; $display("FAIL good_pulses got %0d want 1", load_cnt - base); end
  endtask

`ifdef CHECKSUM_EN
  task automatic test_bad_checksum();
    logic [47:0] f;
    int base;
    f = 48'h01_02_10_20_30_40;
    base = load_cnt;
    send_fields(f);
    send_byte(8'h00);
    exp_err++;
    n_cmp++; if (bus.load !== 1'b0) begin n_fail++; $display("FAIL badck_load got %b want 0", bus.load); end
    n_cmp++; if (bus.err_cnt !== exp_err) begin n_fail++; $display("FAIL badck_err got %0d want %0d", bus.err_cnt, exp_err); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL badck_busy got %b want 0", bus.busy); end
    f = 48'h0A_01_22_33_44_55;
    send_frame(f);
    exp_instr++;
    n_cmp++; if (bus.load !== 1'b1 || fields_now() !== f) begin n_fail++; $display("FAIL badck_recover got load=%b fields=%h want load=1 fields=%h", bus.load, fields_now(), f); end
    n_cmp++; if (load_cnt - base !== 0 || bus.instr_cnt !== exp_instr) begin n_fail++; $display("FAIL badck_counts got pulses=%0d instr=%0d want 0 and %0d", load_cnt - base, bus.instr_cnt, exp_instr); end
  endtask
`endif

  task automatic test_timeout();
    logic [47:0] f;
    int base;
    base = load_cnt;
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h02);
    repeat (TO - 1) @(posedge clk);
    #1;
    n_cmp++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL tmo_busy_before got %b want 1", bus.busy); end
    @(posedge clk); #1;
    exp_err++;
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL tmo_busy_after got %b want 0", bus.busy); end
    n_cmp++; if (bus.err_cnt !== exp_err) begin n_fail++; $display("FAIL tmo_err got %0d want %0d", bus.err_cnt, exp_err); end
    n_cmp++; if (load_cnt !== base) begin n_fail++; $display("FAIL tmo_noload got %0d want %0d", load_cnt, base); end
    send_byte(8'h55);
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL tmo_drop got busy=%b want 0", bus.busy); end
    f = 48'h03_01_AB_CD_EF_12;
    send_frame(f);
    exp_instr++;
    n_cmp++; if (bus.load !== 1'b1 || fields_now() !== f) begin n_fail++; $display("FAIL tmo_restart got load=%b fields=%h want load=1 fields=%h", bus.load, fields_now(), f); end
    n_cmp++; if (bus.instr_cnt !== exp_instr) begin n_fail++; $display("FAIL tmo_instr got %0d want %0d", bus.instr_cnt, exp_instr); end
  endtask

  task automatic test_mid_reset();
    logic [47:0] f;
    send_byte(8'hA5);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_instr = 8'd0;
    exp_err   = 8'd0;
    n_cmp++; if (fields_now() !== 48'h0) begin n_fail++; $display("FAIL mrst_fields got %h want 0", fields_now()); end
    n_cmp++; if ({bus.load, bus.busy, bus.done, bus.instr_cnt, bus.err_cnt} !== 19'h0) begin n_fail++; $display("FAIL mrst_status got busy=%b instr=%0d err=%0d want all 0", bus.busy, bus.instr_cnt, bus.err_cnt); end
    f = 48'h05_06_07_08_09_0A;
    send_frame(f);
    exp_instr++;
    n_cmp++; if (bus.load !== 1'b1 || fields_now() !== f) begin n_fail++; $display("FAIL mrst_frame got load=%b fields=%h want load=1 fields=%h", bus.load, fields_now(), f); end
    n_cmp++; if (bus.instr_cnt !== exp_instr) begin n_fail++; $display("FAIL mrst_instr got %0d want %0d", bus.instr_cnt, exp_instr); end
  endtask

  task automatic test_expiry_race();
    logic [47:0] f;
    f = 48'h0C_0D_0E_0F_10_11;
    send_byte(8'hA5);
    send_byte(f[47:40]);
    repeat (TO - 1) @(posedge clk);
    #1;
    send_byte(f[39:32]);
    n_cmp++; if (bus.busy !== 1'b1 || bus.err_cnt !== exp_err) begin n_fail++; $display("FAIL race_accept got busy=%b err=%0d want busy=1 err=%0d", bus.busy, bus.err_cnt, exp_err); end
    for (int i = 2; i < 6; i++) send_byte(f[47-8*i -: 8]);
`ifdef CHECKSUM_EN
    send_byte(xor6(f));
`endif
    exp_instr++;
    n_cmp++; if (bus.load !== 1'b1 || fields_now() !== f) begin n_fail++; $display("FAIL race_frame got load=%b fields=%h want load=1 fields=%h", bus.load, fields_now(), f); end
  endtask

  task automatic test_sync_as_data();
    logic [47:0] f;
    f = {6{8'hA5}};
    send_frame(f);
    exp_instr++;
    n_cmp++; if (bus.load !== 1'b1 || fields_now() !== f) begin n_fail++; $display("FAIL a5data got load=%b fields=%h want load=1 fields=%h", bus.load, fields_now(), f); end
    n_cmp++; if (bus.instr_cnt !== exp_instr || bus.err_cnt !== exp_err) begin n_fail++; $display("FAIL a5data_counts got instr=%0d err=%0d want %0d %0d", bus.instr_cnt, bus.err_cnt, exp_instr, exp_err); end
  endtask

  task automatic test_back_to_back();
    logic [47:0] f;
    int base;
    do_reset();
    base = load_cnt;
    for (int k = 0; k < NI; k++) begin
      f = {8'(k + 1), 8'h20, 8'(k * 3), 8'h5A, 8'hC3, 8'(8'hF0 - k)};
      send_frame(f);
      n_cmp++; if (bus.load !== 1'b1 || fields_now() !== f) begin n_fail++; $display("FAIL b2b_frame%0d got load=%b fields=%h want load=1 fields=%h", k, bus.load, fields_now(), f); end
      n_cmp++; if (bus.instr_cnt !== 8'(k + 1) || bus.done !== (k == NI - 1)) begin n_fail++; $display("FAIL b2b_cnt%0d got instr=%0d done=%b want %0d %b", k, bus.instr_cnt, bus.done, k + 1, k == NI - 1); end
    end
    send_byte(8'hA5);
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL done_ignore_sync got busy=%b want 0", bus.busy); end
    for (int i = 0; i < 7; i++) send_byte(8'h10 + 8'(i));
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (bus.instr_cnt !== 8'(NI) || bus.done !== 1'b1) begin n_fail++; $display("FAIL done_hold got instr=%0d done=%b want %0d 1", bus.instr_cnt, bus.done, NI); end
    n_cmp++; if (load_cnt - base !== NI) begin n_fail++; $display("FAIL done_pulses got %0d want %0d", load_cnt - base, NI); end
  endtask

  initial begin
    rst = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    test_reset();
    test_good_frame();
`ifdef CHECKSUM_EN
    test_bad_checksum();
`endif
    test_timeout();
    test_mid_reset();
    test_expiry_race();
    test_sync_as_data();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
